// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: shared types for the RV32I sequencer, LSU and hazard logic.
//   state_t       sequencer FSM encoding
//   cause_t       trap_cause codes
//   ID_*          decoder instruction ids (6-bit); ids above ID_EBREAK are illegal
//   classify()    instr_id -> instr_class_t flags
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT_I, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_ECALL    = 2'b10,
        CAUSE_MISALIGN = 2'b11
    } cause_t;

    localparam logic [5:0] ID_ILLEGAL = 6'd0;
    localparam logic [5:0] ID_LUI     = 6'd1;
    localparam logic [5:0] ID_AUIPC   = 6'd2;
    localparam logic [5:0] ID_JAL     = 6'd3;
    localparam logic [5:0] ID_JALR    = 6'd4;
    localparam logic [5:0] ID_BEQ     = 6'd5;
    localparam logic [5:0] ID_BNE     = 6'd6;
    localparam logic [5:0] ID_BLT     = 6'd7;
    localparam logic [5:0] ID_BGE     = 6'd8;
    localparam logic [5:0] ID_BLTU    = 6'd9;
    localparam logic [5:0] ID_BGEU    = 6'd10;
    localparam logic [5:0] ID_LB      = 6'd11;
    localparam logic [5:0] ID_LH      = 6'd12;
    localparam logic [5:0] ID_LW      = 6'd13;
    localparam logic [5:0] ID_LBU     = 6'd14;
    localparam logic [5:0] ID_LHU     = 6'd15;
    localparam logic [5:0] ID_SB      = 6'd16;
    localparam logic [5:0] ID_SH      = 6'd17;
    localparam logic [5:0] ID_SW      = 6'd18;
    localparam logic [5:0] ID_ADDI    = 6'd19;
    localparam logic [5:0] ID_AND     = 6'd37;
    localparam logic [5:0] ID_FENCE   = 6'd38;
    localparam logic [5:0] ID_ECALL   = 6'd39;
    localparam logic [5:0] ID_EBREAK  = 6'd40;

    typedef struct packed {
        logic illegal;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic ecall;
        logic ebreak;
        logic writes_rd;
    } instr_class_t;

    function automatic logic is_load(input logic [5:0] id);
        return id inside {[ID_LB:ID_LHU]};
    endfunction

    function automatic logic is_store(input logic [5:0] id);
        return id inside {[ID_SB:ID_SW]};
    endfunction

    function automatic logic is_branch(input logic [5:0] id);
        return id inside {[ID_BEQ:ID_BGEU]};
    endfunction

    // Everything except branches, stores, fence and the csr-less system ops
    // produces a value for rd (jal/jalr write the link address).
    function automatic logic writes_rd(input logic [5:0] id);
        return id inside {[ID_LUI:ID_JALR], [ID_LB:ID_LHU], [ID_ADDI:ID_AND]};
    endfunction

    function automatic instr_class_t classify(input logic [5:0] id);
        instr_class_t c;
        c.illegal   = id == ID_ILLEGAL || id > ID_EBREAK;
        c.load      = is_load(id);
        c.store     = is_store(id);
        c.branch    = is_branch(id);
        c.jump      = id == ID_JAL || id == ID_JALR;
        c.ecall     = id == ID_ECALL;
        c.ebreak    = id == ID_EBREAK;
        c.writes_rd = writes_rd(id);
        return c;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction/data memory handshake bundle of the sequencer.
//   imem_req/imem_addr -> imem_gnt, imem_rvalid/imem_rdata  (fetch)
//   dmem_req/dmem_we   -> dmem_done                         (load/store)
//   master = sequencer side, slave = memory side
interface core_sequencer_if #(parameter int XLEN = 32);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_done;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_gnt, imem_rvalid, imem_rdata, dmem_done
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_gnt, imem_rvalid, imem_rdata, dmem_done
    );
endinterface

// File: rtl/seq_instr_class.sv
// seq_instr_class: combinational decode of dec_instr_id into class flags.
//   id   in  6   decoder instruction id
//   cls  out     instr_class_t flags
module seq_instr_class
    import core_sequencer_pkg::*;
(
    input  logic [5:0]   id,
    output instr_class_t cls
);
    assign cls = classify(id);
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/WAIT_I/DECODE/EXEC/MEM/WB/HALT control FSM of the RV32I core.
//   clk, rst_n                  clock, asynchronous active-low reset
//   bus (master)                imem/dmem request handshakes
//   instr_o                     fetched instruction, held DECODE..WB
//   dec_instr_id                decoder id, sampled in EXEC
//   br_taken, br_target         ALU branch result, sampled in EXEC
//   alu_en, rf_we               EXEC / WB one-cycle strobes
//   pc, halt, trap, trap_cause  architectural PC and stop status
//   perf_cycle, perf_instret    only when SEQ_PERF_CNT_EN is defined
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
)(
    input  logic              clk,
    input  logic              rst_n,
    core_sequencer_if.master  bus,
    output logic [31:0]       instr_o,
    input  logic [5:0]        dec_instr_id,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_target,
    output logic              alu_en,
    output logic              rf_we,
    output logic [XLEN-1:0]   pc,
    output logic              halt,
    output logic              trap,
    output logic [1:0]        trap_cause
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [63:0]       perf_cycle,
    output logic [63:0]       perf_instret
`endif
);
    state_t          state, state_d;
    cause_t          cause_q, cause_d;
    instr_class_t    cls;
    logic            redirect, retire;
    logic            take_q, store_q, wrd_q;
    logic [XLEN-1:0] target_q;

    seq_instr_class u_class (.id(dec_instr_id), .cls(cls));

    assign redirect       = cls.jump || (cls.branch && br_taken);
    assign bus.imem_req   = state == S_FETCH;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = state == S_MEM;
    assign bus.dmem_we    = state == S_MEM && store_q;
    assign alu_en         = state == S_EXEC;
    assign rf_we          = state == S_WB && wrd_q;
    assign halt           = state == S_HALT;
    assign trap           = cause_q != CAUSE_NONE;
    assign trap_cause     = cause_q;

    always_comb begin
        state_d = state;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state)
            S_FETCH:  state_d = bus.imem_gnt ? S_WAIT_I : S_FETCH;
            S_WAIT_I: state_d = bus.imem_rvalid ? S_DECODE : S_WAIT_I;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (cls.illegal) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls.ecall) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_ECALL;
                end else if (cls.ebreak) begin
                    state_d = S_HALT;
                end else if (cls.load || cls.store) begin
                    state_d = S_MEM;
                end else if (redirect && br_target[1:0] != 2'b00) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Stores retire straight out of MEM; loads still need the WB strobe.
                if (bus.dmem_done) begin
                    state_d = store_q ? S_FETCH : S_WB;
                    retire  = store_q;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            cause_q  <= CAUSE_NONE;
            pc       <= PC_RESET;
            instr_o  <= '0;
            take_q   <= 1'b0;
            store_q  <= 1'b0;
            wrd_q    <= 1'b0;
            target_q <= '0;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
            if (state == S_WAIT_I && bus.imem_rvalid)
                instr_o <= bus.imem_rdata;
            // Capture the ALU's branch result and class in EXEC so MEM/WB/retire
            // do not depend on the decoder or ALU holding their outputs.
            if (state == S_EXEC) begin
                take_q   <= redirect;
                target_q <= br_target;
                store_q  <= cls.store;
                wrd_q    <= cls.writes_rd;
            end
            if (retire)
                pc <= take_q ? target_q : pc + XLEN'(4);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (state != S_HALT)
                perf_cycle <= perf_cycle + 64'd1;
            if (retire)
                perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed self-checking bench for core_sequencer.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam logic [31:0] ADDI_W = 32'h0010_0093;
    localparam logic [31:0] LW_W   = 32'h0000_a103;
    localparam logic [31:0] SW_W   = 32'h0020_a223;
    localparam logic [31:0] BEQ_W  = 32'h0000_0863;
    localparam logic [31:0] JAL_W  = 32'h0000_006f;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_o, br_target, pc;
    logic [5:0]  dec_instr_id;
    logic        br_taken, alu_en, rf_we, halt, trap, seen;
    logic [1:0]  trap_cause;
`ifdef SEQ_PERF_CNT_EN
    logic [63:0] perf_cycle, perf_instret;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    core_sequencer_if bus();

    core_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .instr_o      (instr_o),
        .dec_instr_id (dec_instr_id),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .alu_en       (alu_en),
        .rf_we        (rf_we),
        .pc           (pc),
        .halt         (halt),
        .trap         (trap),
        .trap_cause   (trap_cause)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycle   (perf_cycle),
        .perf_instret (perf_instret)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts at a FETCH negedge, returns at the EXEC negedge.
    task automatic to_exec(input logic [31:0] w, input logic [5:0] id);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = w;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        dec_instr_id    = id;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.dmem_done = 0;
        dec_instr_id = 0; br_taken = 0; br_target = 0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_instr", instr_o, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_halt", halt, 0);
        chk("rst_trap", trap, 0);
        chk("rst_cause", trap_cause, 0);
        rst_n = 1'b1;

        // addi: FETCH, WAIT_I, DECODE, EXEC, WB
        chk("addi_req", bus.imem_req, 1);
        chk("addi_addr", bus.imem_addr, 32'h8000_0000);
        bus.imem_gnt = 1;
        @(negedge clk);
        bus.imem_gnt = 0;
        chk("waiti_req", bus.imem_req, 0);
        bus.imem_rvalid = 1; bus.imem_rdata = ADDI_W;
        @(negedge clk);
        bus.imem_rvalid = 0;
        chk("decode_instr", instr_o, ADDI_W);
        dec_instr_id = ID_ADDI;
        @(negedge clk);
        chk("exec_alu_en", alu_en, 1);
        chk("exec_rf_we", rf_we, 0);
        @(negedge clk);
        chk("wb_rf_we", rf_we, 1);
        chk("wb_alu_en", alu_en, 0);
        @(negedge clk);
        chk("addi_pc", pc, 32'h8000_0004);
        chk("addi_refetch", bus.imem_req, 1);
        chk("addi_rf_we_off", rf_we, 0);

        // lw with dmem_done on the third MEM cycle
        to_exec(LW_W, ID_LW);
        @(negedge clk);
        chk("lw_req1", bus.dmem_req, 1);
        chk("lw_we", bus.dmem_we, 0);
        chk("lw_no_wb1", rf_we, 0);
        @(negedge clk);
        chk("lw_req2", bus.dmem_req, 1);
        @(negedge clk);
        chk("lw_req3", bus.dmem_req, 1);
        bus.dmem_done = 1;
        @(negedge clk);
        bus.dmem_done = 0;
        chk("lw_req_off", bus.dmem_req, 0);
        chk("lw_rf_we", rf_we, 1);
        @(negedge clk);
        chk("lw_pc", pc, 32'h8000_0008);

        // sw retires from MEM without WB
        to_exec(SW_W, ID_SW);
        @(negedge clk);
        chk("sw_req", bus.dmem_req, 1);
        chk("sw_we", bus.dmem_we, 1);
        bus.dmem_done = 1;
        @(negedge clk);
        bus.dmem_done = 0;
        chk("sw_no_wb", rf_we, 0);
        chk("sw_fetch", bus.imem_req, 1);
        chk("sw_pc", pc, 32'h8000_000C);

        // beq taken, aligned
        to_exec(BEQ_W, ID_BEQ);
        br_taken = 1; br_target = 32'h8000_0010;
        @(negedge clk);
        br_taken = 0; br_target = 0;
        chk("beq_no_rf_we", rf_we, 0);
        @(negedge clk);
        chk("beq_pc", pc, 32'h8000_0010);

        // jal to the top of the address space, then addi wraps pc
        to_exec(JAL_W, ID_JAL);
        br_taken = 1; br_target = 32'hFFFF_FFFC;
        @(negedge clk);
        br_taken = 0; br_target = 0;
        chk("jal_rf_we", rf_we, 1);
        @(negedge clk);
        chk("jal_pc", pc, 32'hFFFF_FFFC);
        to_exec(ADDI_W, ID_ADDI);
        repeat (2) @(negedge clk);
        chk("wrap_pc", pc, 32'h0000_0000);
`ifdef SEQ_PERF_CNT_EN
        chk("wrap_instret", perf_instret, 64'd6);
`endif

        // taken beq to a misaligned target
        to_exec(BEQ_W, ID_BEQ);
        br_taken = 1; br_target = 32'h0000_0012;
        @(negedge clk);
        br_taken = 0; br_target = 0;
        chk("mis_halt", halt, 1);
        chk("mis_trap", trap, 1);
        chk("mis_cause", trap_cause, 2'b11);
        chk("mis_pc", pc, 32'h0000_0000);
        chk("mis_rf_we", rf_we, 0);

        // illegal id: halt and stay quiet
        do_reset();
        chk("ill_rst_halt", halt, 0);
        to_exec(32'hFFFF_FFFF, 6'd63);
        @(negedge clk);
        chk("ill_halt", halt, 1);
        chk("ill_trap", trap, 1);
        chk("ill_cause", trap_cause, 2'b01);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_req || bus.dmem_req) seen = 1;
        end
        chk("ill_no_req", seen, 0);
        chk("ill_still_halt", halt, 1);

        // ecall
        do_reset();
        to_exec(32'h0000_0073, ID_ECALL);
        @(negedge clk);
        chk("ecall_halt", halt, 1);
        chk("ecall_trap", trap, 1);
        chk("ecall_cause", trap_cause, 2'b10);

        // ebreak halts without a trap
        do_reset();
        to_exec(32'h0010_0073, ID_EBREAK);
        @(negedge clk);
        chk("ebreak_halt", halt, 1);
        chk("ebreak_trap", trap, 0);
        chk("ebreak_cause", trap_cause, 2'b00);

        // reset while waiting for instruction data; stale rvalid ignored
        do_reset();
        to_exec(ADDI_W, ID_ADDI);
        repeat (2) @(negedge clk);
        chk("pre_rst_pc", pc, 32'h8000_0004);
        bus.imem_gnt = 1;
        @(negedge clk);
        bus.imem_gnt = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_pc", pc, 32'h8000_0000);
        chk("async_rst_instr", instr_o, 0);
        chk("async_rst_req", bus.imem_req, 1);
        @(negedge clk);
        rst_n = 1;
        bus.imem_rvalid = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rvalid = 0;
        chk("stale_still_fetch", bus.imem_req, 1);
        chk("stale_instr", instr_o, 0);
        to_exec(32'h0020_0113, ID_ADDI);
        chk("post_rst_instr", instr_o, 32'h0020_0113);
        @(negedge clk);
        chk("post_rst_rf_we", rf_we, 1);
        @(negedge clk);
        chk("post_rst_pc", pc, 32'h8000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
